// File: rtl/calc_cu_if.sv
// Control/status bundle between the smallCALC control unit and its datapath/top level.
// master = control unit side, slave = datapath/top side.
interface calc_cu_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             go;
    logic [1:0]       op;
    logic [1:0]       s1;
    logic [1:0]       wa;
    logic             we;
    logic [1:0]       raa;
    logic             rea;
    logic [1:0]       rab;
    logic             reb;
    logic [1:0]       c;
    logic             s2;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] op_cnt;

    modport master (
        input  go, op,
        output s1, wa, we, raa, rea, rab, reb, c, s2, busy, done, op_cnt
    );

    modport slave (
        output go, op,
        input  s1, wa, we, raa, rea, rab, reb, c, s2, busy, done, op_cnt
    );
endinterface

// File: rtl/calc_cu.sv
// smallCALC control unit: sequences LOAD_A -> LOAD_B -> EXEC -> OUT per accepted go and
// drives Moore-decoded datapath controls plus busy/done and a completed-operation counter.
module calc_cu #(
    parameter int unsigned CNT_W = 8
) (
    input logic       i_clk,
    input logic       i_rst_n,
    calc_cu_if.master bus
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoadA = 3'd1,
        StLoadB = 3'd2,
        StExec  = 3'd3,
        StOut   = 3'd4
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [1:0]       r_op_q;
    logic [CNT_W-1:0] r_op_cnt;
    logic             w_accept;

    // go is only honoured where a new operation may begin
    assign w_accept = bus.go && ((r_state == StIdle) || (r_state == StOut));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_op_q   <= 2'b00;
            r_op_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op_q <= bus.op;
            end
            if (r_state == StOut) begin
                r_op_cnt <= r_op_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next = StIdle;
        case (r_state)
            StIdle:  w_state_next = bus.go ? StLoadA : StIdle;
            StLoadA: w_state_next = StLoadB;
            StLoadB: w_state_next = StExec;
            StExec:  w_state_next = StOut;
            StOut:   w_state_next = bus.go ? StLoadA : StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        bus.s1   = 2'b00;
        bus.wa   = 2'b00;
        bus.we   = 1'b0;
        bus.raa  = 2'b00;
        bus.rea  = 1'b0;
        bus.rab  = 2'b00;
        bus.reb  = 1'b0;
        bus.c    = 2'b00;
        bus.s2   = 1'b0;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (r_state)
            StLoadA: begin
                bus.s1   = 2'b11;
                bus.wa   = 2'b00;
                bus.we   = 1'b1;
                bus.busy = 1'b1;
            end
            StLoadB: begin
                bus.s1   = 2'b10;
                bus.wa   = 2'b01;
                bus.we   = 1'b1;
                bus.busy = 1'b1;
            end
            StExec: begin
                bus.s1   = 2'b00;
                bus.wa   = 2'b10;
                bus.we   = 1'b1;
                bus.raa  = 2'b00;
                bus.rea  = 1'b1;
                bus.rab  = 2'b01;
                bus.reb  = 1'b1;
                bus.c    = r_op_q;
                bus.busy = 1'b1;
            end
            StOut: begin
                bus.s1   = 2'b01;
                bus.wa   = 2'b10;
                bus.raa  = 2'b00;
                bus.rea  = 1'b1;
                bus.rab  = 2'b01;
                bus.reb  = 1'b1;
                bus.c    = r_op_q;
                bus.s2   = 1'b1;
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.op_cnt = r_op_cnt;

endmodule

// File: tb/tb_calc_cu.sv
// Directed bench for calc_cu with a small behavioural 3-bit datapath attached to its controls.
module tb_calc_cu;

    localparam int ST_IDLE  = 0;
    localparam int ST_LOADA = 1;
    localparam int ST_LOADB = 2;
    localparam int ST_EXEC  = 3;
    localparam int ST_OUT   = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    calc_cu_if #(.CNT_W(8)) bus ();

    calc_cu #(.CNT_W(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    // Datapath model: 4x3-bit register file, input mux, ALU and output mux
    logic [2:0] rf [4];
    logic [2:0] in1, in2, dp_a, dp_b, dp_alu, dp_wd, dp_out;

    always_comb begin
        dp_a = bus.rea ? rf[bus.raa] : 3'd0;
        dp_b = bus.reb ? rf[bus.rab] : 3'd0;
        case (bus.c)
            2'b00:   dp_alu = dp_a + dp_b;
            2'b01:   dp_alu = dp_a - dp_b;
            2'b10:   dp_alu = dp_a & dp_b;
            default: dp_alu = dp_a ^ dp_b;
        endcase
        case (bus.s1)
            2'b11:   dp_wd = in1;
            2'b10:   dp_wd = in2;
            default: dp_wd = dp_alu;
        endcase
        dp_out = bus.s2 ? dp_alu : 3'd0;
    end

    always @(posedge clk) begin
        if (bus.we) rf[bus.wa] <= dp_wd;
    end

    function automatic logic [15:0] ctl_vec();
        return {bus.s1, bus.wa, bus.we, bus.raa, bus.rea, bus.rab, bus.reb, bus.c, bus.s2,
                bus.busy, bus.done};
    endfunction

    function automatic logic [15:0] exp_ctl(input int st, input logic [1:0] cv);
        logic [1:0] s1, wa, raa, rab, cc;
        logic       we, rea, reb, s2, busy, done;
        {s1, wa, raa, rab, cc} = '0;
        {we, rea, reb, s2, busy, done} = '0;
        case (st)
            ST_LOADA: begin s1 = 2'b11; we = 1'b1; busy = 1'b1; end
            ST_LOADB: begin s1 = 2'b10; wa = 2'b01; we = 1'b1; busy = 1'b1; end
            ST_EXEC: begin
                wa = 2'b10; we = 1'b1; rea = 1'b1; rab = 2'b01; reb = 1'b1; cc = cv;
                busy = 1'b1;
            end
            ST_OUT: begin
                s1 = 2'b01; wa = 2'b10; rea = 1'b1; rab = 2'b01; reb = 1'b1; cc = cv;
                s2 = 1'b1; busy = 1'b1; done = 1'b1;
            end
            default: ;
        endcase
        return {s1, wa, we, raa, rea, rab, reb, cc, s2, busy, done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one op from IDLE and walks it to the following IDLE cycle
    task automatic run_op(input string tag, input logic [1:0] opv, input logic [2:0] exp_out,
                          input logic [7:0] cnt_after);
        bus.go = 1'b1;
        bus.op = opv;
        tick();
        bus.go = 1'b0;
        bus.op = ~opv;
        chk({tag, "_loada"}, 32'(ctl_vec()), 32'(exp_ctl(ST_LOADA, 2'b00)));
        tick();
        chk({tag, "_loadb"}, 32'(ctl_vec()), 32'(exp_ctl(ST_LOADB, 2'b00)));
        tick();
        chk({tag, "_exec"}, 32'(ctl_vec()), 32'(exp_ctl(ST_EXEC, opv)));
        tick();
        chk({tag, "_out"}, 32'(ctl_vec()), 32'(exp_ctl(ST_OUT, opv)));
        chk({tag, "_dpout"}, 32'(dp_out), 32'(exp_out));
        chk({tag, "_r2"}, 32'(rf[2]), 32'(exp_out));
        tick();
        chk({tag, "_idle"}, 32'(ctl_vec()), 32'(exp_ctl(ST_IDLE, 2'b00)));
        chk({tag, "_cnt"}, 32'(bus.op_cnt), 32'(cnt_after));
    endtask

    initial begin
        int done_cnt;
        rst_n  = 1'b0;
        bus.go = 1'b1;
        bus.op = 2'b11;
        in1    = 3'd3;
        in2    = 3'd5;

        // Reset held with go=1
        tick();
        tick();
        chk("rst_ctl", 32'(ctl_vec()), 32'(exp_ctl(ST_IDLE, 2'b00)));
        chk("rst_cnt", 32'(bus.op_cnt), 32'd0);

        // Release with go=1: first edge starts an add of 3+5
        rst_n = 1'b1;
        run_op("add", 2'b00, 3'd0, 8'd1);

        in1 = 3'd6;
        in2 = 3'd3;
        run_op("sub", 2'b01, 3'd3, 8'd2);
        run_op("and", 2'b10, 3'd2, 8'd3);
        run_op("xor", 2'b11, 3'd5, 8'd4);

        // op changes while busy are ignored; go held through OUT chains the next op
        bus.go = 1'b1;
        bus.op = 2'b00;
        tick();
        bus.op = 2'b11;
        tick();
        tick();
        chk("ign_exec", 32'(ctl_vec()), 32'(exp_ctl(ST_EXEC, 2'b00)));
        tick();
        chk("ign_out", 32'(ctl_vec()), 32'(exp_ctl(ST_OUT, 2'b00)));
        chk("ign_dpout", 32'(dp_out), 32'd1);
        tick();
        chk("ign_b2b_loada", 32'(ctl_vec()), 32'(exp_ctl(ST_LOADA, 2'b00)));
        tick();
        tick();
        chk("ign_b2b_exec", 32'(ctl_vec()), 32'(exp_ctl(ST_EXEC, 2'b11)));
        bus.go = 1'b0;
        tick();
        chk("ign_b2b_out", 32'(ctl_vec()), 32'(exp_ctl(ST_OUT, 2'b11)));
        chk("ign_b2b_dpout", 32'(dp_out), 32'd5);
        tick();
        chk("ign_idle_cnt", 32'(bus.op_cnt), 32'd6);

        // Back-to-back: go high for 12 edges gives 3 ops, done every 4th cycle
        bus.go   = 1'b1;
        bus.op   = 2'b01;
        done_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("b2b_busy_%0d", k), 32'(bus.busy), 32'd1);
            chk($sformatf("b2b_done_%0d", k), 32'(bus.done), 32'((k % 4) == 0));
            if (bus.done) done_cnt++;
        end
        bus.go = 1'b0;
        tick();
        chk("b2b_ndone", 32'(done_cnt), 32'd3);
        chk("b2b_idle", 32'(ctl_vec()), 32'(exp_ctl(ST_IDLE, 2'b00)));
        chk("b2b_cnt", 32'(bus.op_cnt), 32'd9);

        // Reset during EXEC
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        tick();
        tick();
        chk("midrst_exec", 32'(ctl_vec()), 32'(exp_ctl(ST_EXEC, 2'b01)));
        rst_n = 1'b0;
        tick();
        chk("midrst_ctl", 32'(ctl_vec()), 32'(exp_ctl(ST_IDLE, 2'b00)));
        chk("midrst_we", 32'(bus.we), 32'd0);
        chk("midrst_cnt", 32'(bus.op_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("midrst_stay", 32'(bus.busy), 32'd0);

        // 256 back-to-back ops wrap the 8-bit counter
        bus.go = 1'b1;
        bus.op = 2'b00;
        for (int k = 1; k <= 1024; k++) begin
            tick();
        end
        chk("wrap_out", 32'(bus.done), 32'd1);
        chk("wrap_pre_cnt", 32'(bus.op_cnt), 32'd255);
        bus.go = 1'b0;
        tick();
        chk("wrap_cnt", 32'(bus.op_cnt), 32'd0);
        chk("wrap_idle", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
